// File: rtl/spi_slave_core.sv
// SPI responder: oversamples the SPI pads on wb_clk_in, shifts a buffered tx word out on miso
// and deserializes mosi. Define SPI_SLAVE_IRQ_EN to build the interrupt flop behind int_o.
module spi_slave_core #(
  parameter int MAX_CHAR    = 32,
  parameter int CLEN_W      = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic                wb_clk_in,
  input  logic                wb_rst_in,
  input  logic                sclk_in,
  input  logic                mosi_in,
  input  logic                ss_n_in,
  output logic                miso_o,
  output logic                miso_oe_o,
  input  logic [CLEN_W-1:0]   char_len_in,
  input  logic                lsb_in,
  input  logic                tx_neg_in,
  input  logic                rx_neg_in,
  input  logic [MAX_CHAR-1:0] tx_data_in,
  input  logic                tx_load_in,
  output logic                tx_ready_o,
  output logic [MAX_CHAR-1:0] rx_data_o,
  output logic                rx_valid_o,
  output logic                busy_o,
  output logic                undr_o,
  output logic                abort_o,
  input  logic                flag_clr_in,
  output logic                int_o,
  input  logic                ie_in
);

  localparam int CNT_W = $clog2(MAX_CHAR + 1);
  localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(MAX_CHAR);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  function automatic logic [CNT_W-1:0] eff_len(input logic [CLEN_W-1:0] clen);
    return (clen == '0) ? MAX_LEN : CNT_W'(clen);
  endfunction

  // Right-align the received bits; LSB-first words build up from the top of the register.
  function automatic logic [MAX_CHAR-1:0] align_rx(input logic [MAX_CHAR-1:0] rx,
                                                   input logic lsb, input logic [CNT_W-1:0] len);
    logic [CNT_W-1:0] shamt;
    shamt = MAX_LEN - len;
    return lsb ? (rx >> shamt) : (rx & ({MAX_CHAR{1'b1}} >> shamt));
  endfunction

  // Stage p0: pad synchronizers; the extra sclk/ss flop holds the previous synchronized sample.
  logic [SYNC_STAGES:0]   sclk_p0;
  logic [SYNC_STAGES:0]   ss_p0;
  logic [SYNC_STAGES-1:0] mosi_p0;

  always_ff @(posedge wb_clk_in or negedge wb_rst_in) begin
    if (!wb_rst_in) begin
      sclk_p0 <= '0;
      ss_p0   <= '1;
      mosi_p0 <= '0;
    end else begin
      sclk_p0 <= {sclk_p0[SYNC_STAGES-1:0], sclk_in};
      ss_p0   <= {ss_p0[SYNC_STAGES-1:0], ss_n_in};
      mosi_p0 <= {mosi_p0[SYNC_STAGES-2:0], mosi_in};
    end
  end

  logic sclk_s, ss_s, mosi_s, sclk_rise, sclk_fall, ss_rise, ss_fall;
  assign sclk_s    = sclk_p0[SYNC_STAGES-1];
  assign ss_s      = ss_p0[SYNC_STAGES-1];
  assign mosi_s    = mosi_p0[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_p0[SYNC_STAGES];
  assign sclk_fall = ~sclk_s & sclk_p0[SYNC_STAGES];
  assign ss_rise   = ss_s & ~ss_p0[SYNC_STAGES];
  assign ss_fall   = ~ss_s & ss_p0[SYNC_STAGES];

  // Stage p1: character FSM, shift registers and flags.
  logic [1:0]          state_p1;
  logic [CNT_W-1:0]    cnt_p1, len_p1;
  logic                lsb_p1, tx_neg_p1, rx_neg_p1, sampled_p1;
  logic [MAX_CHAR-1:0] tx_buf_p1, tx_sh_p1, rx_sh_p1, tx_word;
  logic                start, sample_edge, drive_ok, last_sample, abort_ev;

  assign start       = ((state_p1 == IDLE) && ss_fall) || ((state_p1 == DONE) && !ss_s);
  assign tx_word     = tx_ready_o ? '0 : tx_buf_p1;
  assign sample_edge = rx_neg_p1 ? sclk_fall : sclk_rise;
  assign drive_ok    = (tx_neg_p1 ? sclk_fall : sclk_rise) & sampled_p1;
  assign last_sample = (state_p1 == SHIFT) && sample_edge && ((cnt_p1 + 1'b1) == len_p1);
  // A character that completes on the same cycle ss_n rises counts as complete, not aborted.
  assign abort_ev    = ((state_p1 == LOAD) || (state_p1 == SHIFT)) && ss_rise && !last_sample;

  assign busy_o    = (state_p1 != IDLE);
  assign miso_oe_o = (state_p1 != IDLE);

  // MSB-first words are left-aligned at load so the next bit always sits at the top.
  always_ff @(posedge wb_clk_in) begin
    if (tx_load_in)
      tx_buf_p1 <= tx_data_in;
    if (start)
      tx_sh_p1 <= lsb_in ? tx_word : (tx_word << (MAX_LEN - eff_len(char_len_in)));
    else if ((state_p1 == SHIFT) && drive_ok)
      tx_sh_p1 <= lsb_p1 ? (tx_sh_p1 >> 1) : (tx_sh_p1 << 1);
    if ((state_p1 == SHIFT) && sample_edge)
      rx_sh_p1 <= lsb_p1 ? {mosi_s, rx_sh_p1[MAX_CHAR-1:1]} : {rx_sh_p1[MAX_CHAR-2:0], mosi_s};
  end

  always_ff @(posedge wb_clk_in or negedge wb_rst_in) begin
    if (!wb_rst_in) begin
      state_p1   <= IDLE;
      cnt_p1     <= '0;
      len_p1     <= MAX_LEN;
      lsb_p1     <= 1'b0;
      tx_neg_p1  <= 1'b0;
      rx_neg_p1  <= 1'b0;
      sampled_p1 <= 1'b0;
      miso_o     <= 1'b0;
      tx_ready_o <= 1'b1;
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
      undr_o     <= 1'b0;
      abort_o    <= 1'b0;
    end else begin
      rx_valid_o <= 1'b0;

      if (tx_load_in)  tx_ready_o <= 1'b0;
      else if (start)  tx_ready_o <= 1'b1;

      if (start && tx_ready_o) undr_o <= 1'b1;
      else if (flag_clr_in)    undr_o <= 1'b0;

      if (abort_ev)            abort_o <= 1'b1;
      else if (flag_clr_in)    abort_o <= 1'b0;

      if (start) begin
        cnt_p1     <= '0;
        sampled_p1 <= 1'b0;
        len_p1     <= eff_len(char_len_in);
        lsb_p1     <= lsb_in;
        tx_neg_p1  <= tx_neg_in;
        rx_neg_p1  <= rx_neg_in;
      end

      case (state_p1)
        IDLE: if (ss_fall) state_p1 <= LOAD;
        LOAD: begin
          if (ss_rise) begin
            state_p1 <= IDLE;
          end else begin
            miso_o   <= lsb_p1 ? tx_sh_p1[0] : tx_sh_p1[MAX_CHAR-1];
            state_p1 <= SHIFT;
          end
        end
        SHIFT: begin
          if (sample_edge) begin
            cnt_p1     <= cnt_p1 + 1'b1;
            sampled_p1 <= 1'b1;
          end
          if (drive_ok)
            miso_o <= lsb_p1 ? tx_sh_p1[1] : tx_sh_p1[MAX_CHAR-2];
          if (last_sample)  state_p1 <= DONE;
          else if (ss_rise) state_p1 <= IDLE;
        end
        default: begin
          rx_data_o  <= align_rx(rx_sh_p1, lsb_p1, len_p1);
          rx_valid_o <= 1'b1;
          state_p1   <= ss_s ? IDLE : LOAD;
        end
      endcase
    end
  end

`ifdef SPI_SLAVE_IRQ_EN
  logic int_p2;
  always_ff @(posedge wb_clk_in or negedge wb_rst_in) begin
    if (!wb_rst_in)                            int_p2 <= 1'b0;
    else if (ie_in && (rx_valid_o || abort_ev)) int_p2 <= 1'b1;
    else if (flag_clr_in)                      int_p2 <= 1'b0;
  end
  assign int_o = int_p2;
`else
  logic unused_ie;
  assign unused_ie = ie_in;
  assign int_o     = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench for spi_slave_core: a bit-level SPI master model drives the pads and
// collects miso, while a monitor records every rx_valid_o word.
module tb_spi_slave_core;

  localparam int HALF = 5;
`ifdef SPI_SLAVE_IRQ_EN
  localparam logic IRQ_EXP = 1'b1;
`else
  localparam logic IRQ_EXP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b0, mosi = 1'b0, ss_n = 1'b1;
  logic        miso_o, miso_oe_o, tx_ready_o, rx_valid_o, busy_o, undr_o, abort_o, int_o;
  logic [4:0]  char_len = '0;
  logic        lsb = 1'b0, tx_neg = 1'b0, rx_neg = 1'b0;
  logic [31:0] tx_data = '0, rx_data_o;
  logic        tx_load = 1'b0, flag_clr = 1'b0, ie = 1'b0;

  int passed = 0;
  int total  = 0;
  logic [31:0] rxq[$];

  always #5 clk = ~clk;

  spi_slave_core dut (
    .wb_clk_in(clk), .wb_rst_in(rst_n), .sclk_in(sclk), .mosi_in(mosi), .ss_n_in(ss_n),
    .miso_o(miso_o), .miso_oe_o(miso_oe_o), .char_len_in(char_len), .lsb_in(lsb),
    .tx_neg_in(tx_neg), .rx_neg_in(rx_neg), .tx_data_in(tx_data), .tx_load_in(tx_load),
    .tx_ready_o(tx_ready_o), .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .busy_o(busy_o),
    .undr_o(undr_o), .abort_o(abort_o), .flag_clr_in(flag_clr), .int_o(int_o), .ie_in(ie)
  );

  always @(negedge clk) if (rx_valid_o) rxq.push_back(rx_data_o);

  typedef struct {
    logic [4:0]  clen;
    logic        lsbf, txn, rxn, pre;
    logic [31:0] md, stx, exp_rx, exp_mrx;
    logic        exp_undr;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic clear_flags();
    @(negedge clk); flag_clr = 1'b1;
    @(negedge clk); flag_clr = 1'b0;
  endtask

  task automatic load_tx(input logic [31:0] d);
    @(negedge clk); tx_data = d; tx_load = 1'b1;
    @(negedge clk); tx_load = 1'b0;
  endtask

  // Master: drives mosi on its tx edge (after the first sample) and samples miso on its rx edge.
  task automatic master_char(input int L, input logic lsbf, input logic txn, input logic rxn,
                             input logic [31:0] md, input logic end_ss, output logic [31:0] mr);
    int ns;
    logic fall;
    mr = '0;
    ns = 0;
    @(negedge clk);
    mosi = lsbf ? md[0] : md[L-1];
    repeat (HALF) @(negedge clk);
    for (int e = 0; e < 2 * L; e++) begin
      fall = ((e % 2) == 1);
      sclk = !fall;
      if (fall == rxn) begin
        mr[lsbf ? ns : L-1-ns] = miso_o;
        ns++;
        if (ns == L && end_ss) begin
          @(negedge clk);
          ss_n = 1'b1;
        end
      end
      if (fall == txn && ns > 0 && ns < L) mosi = lsbf ? md[ns] : md[L-1-ns];
      repeat (HALF) @(negedge clk);
    end
  endtask

  task automatic set_cfg(input logic [4:0] c, input logic l, input logic tn, input logic rn);
    @(negedge clk);
    char_len = c; lsb = l; tx_neg = tn; rx_neg = rn;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [31:0] mr;
    int q0, L;
    L = (v.clen == 0) ? 32 : int'(v.clen);
    set_cfg(v.clen, v.lsbf, v.txn, v.rxn);
    if (v.pre) begin
      load_tx(v.stx);
      chk({tag, "_txready_lo"}, tx_ready_o, 0);
    end
    q0 = rxq.size();
    ss_n = 1'b0;
    repeat (8) @(negedge clk);
    master_char(L, v.lsbf, v.txn, v.rxn, v.md, 1'b1, mr);
    repeat (10) @(negedge clk);
    chk({tag, "_nvalid"}, rxq.size() - q0, 1);
    chk({tag, "_rxdata"}, rx_data_o, v.exp_rx);
    chk({tag, "_master_rx"}, mr, v.exp_mrx);
    chk({tag, "_undr"}, undr_o, v.exp_undr);
    chk({tag, "_abort"}, abort_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_txready"}, tx_ready_o, 1);
    clear_flags();
    chk({tag, "_undr_clr"}, undr_o, 0);
  endtask

  initial begin
    logic [31:0] mr1, mr2;
    logic found;
    int q0;
    vec_t v;

    //            clen   lsb   txn   rxn   pre   mosi word     slave tx      exp rx        exp master rx undr
    vecs[0] = '{5'd4,  1'b1, 1'b0, 1'b1, 1'b1, 32'h0000236F, 32'h00000005, 32'h0000000F, 32'h00000005, 1'b0};
    vecs[1] = '{5'd8,  1'b0, 1'b1, 1'b0, 1'b1, 32'h000000A5, 32'h00000081, 32'h000000A5, 32'h00000081, 1'b0};
    vecs[2] = '{5'd8,  1'b0, 1'b1, 1'b0, 1'b0, 32'h0000005A, 32'h0000FFFF, 32'h0000005A, 32'h00000000, 1'b1};
    vecs[3] = '{5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 32'h12345678, 1'b0};
    vecs[4] = '{5'd12, 1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFFFABC, 32'h000003C5, 32'h00000ABC, 32'h000003C5, 1'b0};
    vecs[5] = '{5'd1,  1'b0, 1'b0, 1'b1, 1'b1, 32'h00000001, 32'h00000001, 32'h00000001, 32'h00000001, 1'b0};
    vecs[6] = '{5'd31, 1'b1, 1'b1, 1'b0, 1'b1, 32'hC0000001, 32'hFFFFFFFF, 32'h40000001, 32'h7FFFFFFF, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_miso", miso_o, 0);
    chk("rst_oe", miso_oe_o, 0);
    chk("rst_txready", tx_ready_o, 1);
    chk("rst_rxdata", rx_data_o, 0);
    chk("rst_rxvalid", rx_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_undr", undr_o, 0);
    chk("rst_abort", abort_o, 0);
    chk("rst_int", int_o, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back characters with ss_n held low; the second word is loaded mid-character.
    set_cfg(5'd8, 1'b0, 1'b1, 1'b0);
    load_tx(32'h81);
    q0 = rxq.size();
    ss_n = 1'b0;
    repeat (8) @(negedge clk);
    chk("b2b_consumed", tx_ready_o, 1);
    load_tx(32'h7E);
    master_char(8, 1'b0, 1'b1, 1'b0, 32'hA5, 1'b0, mr1);
    repeat (10) @(negedge clk);
    master_char(8, 1'b0, 1'b1, 1'b0, 32'h3C, 1'b1, mr2);
    repeat (10) @(negedge clk);
    chk("b2b_nvalid", rxq.size() - q0, 2);
    if (rxq.size() - q0 == 2) begin
      chk("b2b_rx0", rxq[q0], 32'hA5);
      chk("b2b_rx1", rxq[q0+1], 32'h3C);
    end
    chk("b2b_mrx0", mr1, 32'h81);
    chk("b2b_mrx1", mr2, 32'h7E);
    chk("b2b_undr", undr_o, 0);
    chk("b2b_abort", abort_o, 0);

    // Abort after 3 of 8 sample edges, then a clean character.
    set_cfg(5'd8, 1'b0, 1'b1, 1'b0);
    q0 = rxq.size();
    ss_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      sclk = 1'b1; repeat (HALF) @(negedge clk);
      sclk = 1'b0; repeat (HALF) @(negedge clk);
    end
    chk("abort_busy_mid", busy_o, 1);
    ss_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_busy", busy_o, 0);
    chk("abort_flag", abort_o, 1);
    repeat (10) @(negedge clk);
    chk("abort_nvalid", rxq.size() - q0, 0);
    clear_flags();
    chk("abort_clr", abort_o, 0);
    v = '{5'd8, 1'b0, 1'b1, 1'b0, 1'b1, 32'h96, 32'h69, 32'h96, 32'h69, 1'b0};
    run_vec(v, "post_abort");

    // Interrupt: rises the cycle after rx_valid_o when built in, otherwise stays low.
    set_cfg(5'd4, 1'b1, 1'b0, 1'b1);
    ie = 1'b1;
    load_tx(32'h5);
    ss_n = 1'b0;
    repeat (8) @(negedge clk);
    fork
      master_char(4, 1'b1, 1'b0, 1'b1, 32'h9, 1'b1, mr1);
      begin
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
          @(negedge clk);
          if (rx_valid_o) begin
            found = 1'b1;
            break;
          end
        end
        chk("irq_valid_seen", found, 1);
        if (found) begin
          chk("irq_at_valid", int_o, 0);
          @(negedge clk);
          chk("irq_after_valid", int_o, IRQ_EXP);
        end
      end
    join
    repeat (10) @(negedge clk);
    chk("irq_rx", rx_data_o, 32'h9);
    chk("irq_hold", int_o, IRQ_EXP);
    clear_flags();
    chk("irq_clr", int_o, 0);
    ie = 1'b0;

    // Asynchronous reset in the middle of a character.
    set_cfg(5'd8, 1'b0, 1'b0, 1'b1);
    ss_n = 1'b0;
    repeat (8) @(negedge clk);
    chk("mid_oe", miso_oe_o, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_oe", miso_oe_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_rxdata", rx_data_o, 0);
    chk("mid_rst_undr", undr_o, 0);
    ss_n = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_busy", busy_o, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/spi_slave_core.md
Name: spi_slave_core

Overview:
- Synthesizable SPI responder (slave) for the system bus clock domain; it is the far end of the SPI link driven by spi_top.
- Oversamples the sclk, mosi and ss_n pads with wb_clk_in.
- Shifts out a host-loaded transmit word on miso and deserializes mosi into a receive word.
- Character length, bit order and edge selection mirror the spi_top control fields (char_len, lsb, tx_neg, rx_neg), so the two ends can be configured identically.

Parameters:
- MAX_CHAR, 32: widest character in bits; also the tx/rx data width.
- CLEN_W, 5: width of char_len_in; a value of 0 encodes MAX_CHAR.
- SYNC_STAGES, 2: flip-flop depth of the pad synchronizers, minimum 2.

Ports:
- wb_clk_in  in  1  system clock.
- wb_rst_in  in  1  asynchronous active-low reset.
- sclk_in  in  1  SPI clock from the master, asynchronous.
- mosi_in  in  1  master-out data, asynchronous.
- ss_n_in  in  1  slave select, active low, asynchronous.
- miso_o  out  1  slave-out data.
- miso_oe_o  out  1  miso output enable.
- char_len_in  in  CLEN_W  bits per character.
- lsb_in  in  1  1 = LSB first.
- tx_neg_in  in  1  1 = miso changes on the sclk falling edge.
- rx_neg_in  in  1  1 = mosi is sampled on the sclk falling edge.
- tx_data_in  in  MAX_CHAR  next transmit word.
- tx_load_in  in  1  one-cycle strobe: capture tx_data_in into the tx buffer.
- tx_ready_o  out  1  tx buffer empty.
- rx_data_o  out  MAX_CHAR  last received word, right-aligned.
- rx_valid_o  out  1  one-cycle pulse when rx_data_o updates.
- busy_o  out  1  a transfer is in progress.
- undr_o  out  1  sticky: a character started with the tx buffer empty.
- abort_o  out  1  sticky: ss_n deasserted mid-character.
- flag_clr_in  in  1  clears undr_o and abort_o.
- int_o  out  1  interrupt (see Optional Feature).
- ie_in  in  1  interrupt enable.

Behaviour:
- Reset values: miso_o=0, miso_oe_o=0, tx_ready_o=1, rx_data_o=0, rx_valid_o=0, busy_o=0, undr_o=0, abort_o=0, int_o=0. The FSM resets to IDLE.
- Synchronizers and edge detection:
  - sclk, mosi and ss_n each pass through SYNC_STAGES flip-flops; mosi uses the same depth so it stays aligned with sclk.
  - Edges are detected by comparing the last two synchronized samples. Internal reaction is SYNC_STAGES+1 cycles after a pad edge.
  - Required master sclk period is at least 8 wb_clk_in cycles.
- Effective length: L = char_len_in, or MAX_CHAR when char_len_in is 0.
- Sample edge is falling if rx_neg_in else rising. Drive edge is falling if tx_neg_in else rising.
- FSM states:
  - IDLE: miso_oe_o=0, busy_o=0. On synchronized ss_n falling:
    - Load the shift register from the tx buffer and set tx_ready_o=1.
    - If the buffer was empty, load zeros and set undr_o.
    - Clear the bit counter and go to LOAD.
  - LOAD: miso_oe_o=1 and miso_o = first bit (bit 0 if lsb_in, else bit L-1). Go to SHIFT in the same cycle the drive value is set.
  - SHIFT:
    - On each sample edge: shift the sampled mosi into the rx register (into bit L-1 moving down if lsb_in, else into bit 0 moving up), and increment the counter.
    - On each drive edge that follows at least one sample in the current character: present the next tx bit.
    - When the counter reaches L: go to DONE.
  - DONE (1 cycle):
    - Copy the rx register, masked to L bits, to rx_data_o and pulse rx_valid_o.
    - If ss_n is still low: reload as in IDLE for a back-to-back character and go to LOAD.
    - Otherwise go to IDLE.
- Synchronized ss_n rising while in LOAD or SHIFT:
  - Go to IDLE and set abort_o. No rx_valid_o pulse.
  - The partial rx word is discarded; the tx word is lost and not restored.
- tx buffer:
  - tx_load_in while tx_ready_o=1 writes the buffer and clears tx_ready_o.
  - tx_load_in while tx_ready_o=0 overwrites the buffer.
  - tx_load_in in the same cycle the buffer is consumed: the buffer takes the new word and tx_ready_o=0; the consumed word is the old one.
- config inputs are sampled only at ss_n assertion and DONE reload, so changes mid-character have no effect.
- flag_clr_in coinciding with a new set event: set wins.
- Asynchronous reset mid-transfer forces the reset values immediately; miso_oe_o drops.

Optional Feature:
- Macro SPI_SLAVE_IRQ_EN.
- Defined: int_o is set in the cycle after rx_valid_o when ie_in=1, also set on abort when ie_in=1, and cleared by flag_clr_in (set wins).
- Undefined: int_o is tied 0, ie_in is ignored, and no interrupt flop exists.

Test Plan:
- Master control 0x3A04 (L=4, lsb=1, rx_neg=1, tx_neg=0), divider 4; slave char_len=4 with matching edges; master tx 0x236f, slave tx preload 0x5 -> slave rx_data_o=0xF with one rx_valid_o pulse; master receives 0x5; undr_o=0.
- L=8, lsb=0, tx_neg=1, rx_neg=0, master sends 0xA5 then 0x3C with ss_n held low, slave loads 0x81 then 0x7E -> two rx_valid_o pulses with 0xA5 then 0x3C; master receives 0x81 then 0x7E.
- No tx_load before ss_n falls, L=8 -> miso shifts 0x00; undr_o=1; flag_clr_in clears it.
- ss_n raised after 3 of 8 sample edges -> abort_o=1, no rx_valid_o, busy_o=0 within SYNC_STAGES+2 cycles; the next full character is received correctly.
- char_len=0, master sends 0xDEADBEEF -> rx_data_o=0xDEADBEEF.
- With SPI_SLAVE_IRQ_EN and ie_in=1, one 4-bit character -> int_o rises 1 cycle after rx_valid_o and holds until flag_clr_in. Without the macro -> int_o stays 0.
